uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of byte requesters, range 2..8.
REQ-002 SHALL have parameter BITWIDTH, default 8: byte width, equal to the UART data width.
REQ-003 SHALL have parameter MAXBURST, default 4: maximum bytes per grant, range 1..15.
REQ-004 SHALL have port PCLK, input, 1: single clock for all logic.
REQ-005 SHALL have port PRESETN, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, NREQ: requester i offers a byte.
REQ-007 SHALL have port req_data, input, NREQ*BITWIDTH: byte of requester i in bits [i*BITWIDTH +: BITWIDTH].
REQ-008 SHALL have port req_last, input, NREQ: offered byte ends requester i's message.
REQ-009 SHALL have port req_ready, output, NREQ: byte of requester i accepted this cycle.
REQ-010 SHALL have port req_enable, input, NREQ: requester i may be granted.
REQ-011 SHALL have port tx_full, input, 1: UART transmit FIFO full.
REQ-012 SHALL have port wr_uart, output, 1: write strobe to the UART transmit FIFO.
REQ-013 SHALL have port w_data, output, BITWIDTH: byte written to the UART.
REQ-014 SHALL have port grant, output, NREQ: one-hot current owner, all-zero when idle.
REQ-015 SHALL have port busy, output, 1: a grant is active.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and OWN.
REQ-017 In IDLE, if any bit of (req_valid & req_enable) is set, SHALL register a grant to the first such index after ptr (modulo NREQ), enter OWN, clear burst count, and leave req_ready at 0 in that cycle.
REQ-018 In OWN, req_ready[g] SHALL be req_valid[g] & req_enable[g] & !tx_full (combinational); all other req_ready bits SHALL be 0.
REQ-019 wr_uart SHALL equal the OR of req_ready; w_data SHALL equal req_data of the owner g; latency is zero cycles.
REQ-020 Each accepted byte SHALL increment the 4-bit burst count.
REQ-021 OWN SHALL return to IDLE at the next edge on any of: accepted byte with req_last=1; accepted byte that makes the count equal MAXBURST; req_valid[g]=0; req_enable[g]=0. On exit, ptr SHALL be set to g.
REQ-022 tx_full=1 in OWN with req_valid[g]=1 SHALL hold the grant with no timeout and no write.
REQ-023 Every grant SHALL be followed by at least one IDLE cycle (arbitration bubble), so at most one write occurs per cycle.
REQ-024 Requester inputs SHALL be ignored outside OWN and for non-owners; w_data SHALL be 0 when wr_uart=0.

Reset
REQ-025 PRESETN low SHALL asynchronously force: state IDLE, grant 0, busy 0, burst count 0, ptr NREQ-1 (requester 0 has first priority).
REQ-026 While in reset, req_ready, wr_uart and w_data SHALL be 0.
REQ-027 Reset asserted during OWN SHALL abort the burst with no partial write after reset release.

Structure
REQ-028 The shared package SHALL hold the FSM state enum, the BITWIDTH default, and the MAXBURST default.
REQ-029 The design SHALL contain one sub-module, rr_pick: combinational round-robin first-set-after-pointer selector (req vector, ptr -> one-hot grant).

Verification
REQ-030 After reset, req_valid=4'b1111 and all bytes last=1 -> grants in order 0,1,2,3,0, each preceded by a one-cycle bubble.
REQ-031 Requester 2 sends 0xA5,0x5A,0x3C,0xC3,0x11 with last only on 0x11 and MAXBURST=4 -> first four bytes written, grant released, requester 2 re-granted later for 0x11.
REQ-032 tx_full=1 for 5 cycles mid-burst -> wr_uart=0 and req_ready=0 for those cycles, grant held, burst resumes with no byte lost or duplicated.
REQ-033 req_enable[1] cleared while requester 1 owns -> release next edge, ptr=1, next grant goes to requester 2 if valid.
REQ-034 PRESETN pulsed low while in OWN after 2 bytes -> all outputs 0 immediately; after release, requester 0 wins first.
REQ-035 Scoreboard check: byte order on w_data matches each requester's stream, and wr_uart never asserts while tx_full=1.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_t   : arbiter FSM state encoding
//   BITWIDTH_DEF  : default byte width (matches the UART data width)
//   MAXBURST_DEF  : default maximum number of bytes per grant
//   BURST_CNT_W   : width of the per-grant burst counter
package uart_tx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  localparam int BITWIDTH_DEF = 8;
  localparam int MAXBURST_DEF = 4;
  localparam int BURST_CNT_W  = 4;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: returns a one-hot vector marking the
// first set bit of req strictly after position ptr, wrapping modulo N.
//   req : request vector
//   ptr : index of the most recent owner (search starts at ptr+1)
//   gnt : one-hot selection, all-zero when req is empty
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    // k = N wraps back to ptr itself, so the last owner is considered last.
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        gnt[(int'(ptr) + k) % N] = 1'b1;
        found                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding byte requesters into a single UART TX FIFO.
// A requester holds the UART for up to MAXBURST bytes or until its message
// ends; every grant is followed by one idle arbitration cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no owner; pick next eligible requester after ptr
//   ST_OWN   | grant held; owner's bytes pass straight through to UART
//
// Ports:
//   PCLK, PRESETN : clock, asynchronous active-low reset
//   req_valid     : requester i offers a byte
//   req_data      : byte of requester i in [i*BITWIDTH +: BITWIDTH]
//   req_last      : offered byte ends requester i's message
//   req_enable    : requester i may be granted
//   req_ready     : byte of requester i accepted this cycle
//   tx_full       : UART TX FIFO full
//   wr_uart       : write strobe to the UART TX FIFO
//   w_data        : byte written to the UART (0 when not writing)
//   grant         : one-hot current owner, zero when idle
//   busy          : a grant is active
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int BITWIDTH = BITWIDTH_DEF,
  parameter int MAXBURST = MAXBURST_DEF
) (
  input  logic                     PCLK,
  input  logic                     PRESETN,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*BITWIDTH-1:0] req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_enable,
  input  logic                     tx_full,
  output logic                     wr_uart,
  output logic [BITWIDTH-1:0]      w_data,
  output logic [NREQ-1:0]          grant,
  output logic                     busy
);

  localparam int PW = $clog2(NREQ);

  arb_state_t             state;
  logic [PW-1:0]          ptr;
  logic [BURST_CNT_W-1:0] burst_cnt;

  logic [NREQ-1:0]        cand;
  logic [NREQ-1:0]        pick;
  logic [PW-1:0]          owner_idx;
  logic [BITWIDTH-1:0]    owner_data;
  logic                   owner_valid;
  logic                   owner_enable;
  logic                   owner_last;
  logic                   accept;
  logic                   burst_end;
  logic                   release_own;

  assign cand = req_valid & req_enable;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_pick (
    .req (cand),
    .ptr (ptr),
    .gnt (pick)
  );

  // Owner mux driven by the registered one-hot grant; all-zero when idle.
  always_comb begin
    owner_idx    = '0;
    owner_data   = '0;
    owner_valid  = 1'b0;
    owner_enable = 1'b0;
    owner_last   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        owner_idx    = PW'(i);
        owner_data   = req_data[i*BITWIDTH +: BITWIDTH];
        owner_valid  = req_valid[i];
        owner_enable = req_enable[i];
        owner_last   = req_last[i];
      end
    end
  end

  // Pass-through handshake: zero-latency, gated by state so reset and the
  // idle bubble suppress all writes.
  assign accept      = (state == ST_OWN) && owner_valid && owner_enable && !tx_full;
  assign req_ready   = accept ? grant : '0;
  assign wr_uart     = accept;
  assign w_data      = accept ? owner_data : '0;

  assign burst_end   = ((burst_cnt + 4'd1) == BURST_CNT_W'(MAXBURST));
  assign release_own = (accept && (owner_last || burst_end)) || !owner_valid || !owner_enable;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state     <= ST_IDLE;
      grant     <= '0;
      busy      <= 1'b0;
      burst_cnt <= '0;
      ptr       <= PW'(NREQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|cand) begin
            state     <= ST_OWN;
            grant     <= pick;
            busy      <= 1'b1;
            burst_cnt <= '0;
          end
        end
        ST_OWN: begin
          if (accept) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
          if (release_own) begin
            state <= ST_IDLE;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= owner_idx;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int BW   = 8;

  logic                 PCLK = 1'b0;
  logic                 PRESETN = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*BW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_enable = '1;
  logic                 tx_full = 1'b0;
  logic                 wr_uart;
  logic [BW-1:0]        w_data;
  logic [NREQ-1:0]      grant;
  logic                 busy;

  int tests_run = 0;
  int tests_failed = 0;
  int full_viol = 0;
  logic [11:0] wlog [$];

  always #5 PCLK = ~PCLK;

  uart_tx_arbiter #(.NREQ(NREQ), .BITWIDTH(BW), .MAXBURST(4)) dut (
    .PCLK       (PCLK),
    .PRESETN    (PRESETN),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .req_enable (req_enable),
    .tx_full    (tx_full),
    .wr_uart    (wr_uart),
    .w_data     (w_data),
    .grant      (grant),
    .busy       (busy)
  );

  // Record every byte that reaches the UART together with its owner.
  always @(posedge PCLK) begin
    if (wr_uart && tx_full) full_viol++;
    if (wr_uart) wlog.push_back({grant, w_data});
  end

  // Round robin: all four requesters, single-byte messages.
  localparam logic [3:0] RR_G [11] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
  localparam logic [7:0] RR_D [11] = '{8'h00, 8'hA0, 8'h00, 8'hB1, 8'h00, 8'hC2, 8'h00, 8'hD3, 8'h00, 8'hA0, 8'h00};
  localparam logic [11:0] RR_L [5] = '{12'h1A0, 12'h2B1, 12'h4C2, 12'h8D3, 12'h1A0};

  // Burst limit: requester 2 sends five bytes, MAXBURST = 4.
  localparam logic [7:0] BS_S [5] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h11};
  localparam logic [3:0] BS_G [8] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h0};
  localparam logic [7:0] BS_D [8] = '{8'h00, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h00, 8'h11, 8'h00};

  // Back-pressure: requester 1, tx_full for five cycles after first byte.
  localparam logic [7:0] TF_S [4]  = '{8'h10, 8'h20, 8'h30, 8'h40};
  localparam logic       TF_F [11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [3:0] TF_G [11] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
  localparam logic [7:0] TF_D [11] = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h30, 8'h40, 8'h00};

  // Enable drop while requester 1 owns.
  localparam logic [3:0] ED_V  [6] = '{4'h2, 4'h2, 4'h7, 4'h7, 4'h7, 4'h7};
  localparam logic [3:0] ED_EN [6] = '{4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD};
  localparam logic [3:0] ED_G  [6] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h0};
  localparam logic [7:0] ED_D  [6] = '{8'h00, 8'hB0, 8'h00, 8'h00, 8'hE2, 8'h00};

  // Reset during a burst from requester 3.
  localparam logic [3:0] RM_V  [8] = '{4'h8, 4'h8, 4'h8, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9};
  localparam logic       RM_R  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic [7:0] RM_3  [8] = '{8'h71, 8'h71, 8'h72, 8'h73, 8'h73, 8'h73, 8'h73, 8'h73};
  localparam logic [3:0] RM_G  [8] = '{4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
  localparam logic [7:0] RM_D  [8] = '{8'h00, 8'h71, 8'h72, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00};
  localparam logic [11:0] RM_L [3] = '{12'h871, 12'h872, 12'h10F};

  task automatic test_reset();
    PRESETN    = 1'b0;
    req_valid  = '1;
    req_enable = '1;
    req_last   = '1;
    req_data   = 32'hDDCCBBAA;
    tx_full    = 1'b0;
    repeat (3) @(negedge PCLK);
    #1;
    tests_run++;
    if (grant !== 4'h0) begin tests_failed++; $display("FAIL reset_grant: got %h want 0", grant); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++;
    if (req_ready !== 4'h0) begin tests_failed++; $display("FAIL reset_ready: got %h want 0", req_ready); end
    tests_run++;
    if (wr_uart !== 1'b0) begin tests_failed++; $display("FAIL reset_wr: got %b want 0", wr_uart); end
    tests_run++;
    if (w_data !== 8'h00) begin tests_failed++; $display("FAIL reset_wdata: got %h want 0", w_data); end
    @(negedge PCLK);
    req_valid = '0;
    PRESETN   = 1'b1;
    #1;
    tests_run++;
    if (grant !== 4'h0) begin tests_failed++; $display("FAIL reset_release_grant: got %h want 0", grant); end
  endtask

  task automatic test_round_robin();
    int start;
    start      = wlog.size();
    req_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req_last   = '1;
    req_enable = '1;
    tx_full    = 1'b0;
    for (int c = 0; c < 11; c++) begin
      @(negedge PCLK);
      req_valid = '1;
      #1;
      tests_run++;
      if (grant !== RR_G[c]) begin tests_failed++; $display("FAIL rr_grant c%0d: got %h want %h", c, grant, RR_G[c]); end
      tests_run++;
      if (busy !== (RR_G[c] != 4'h0)) begin tests_failed++; $display("FAIL rr_busy c%0d: got %b", c, busy); end
      tests_run++;
      if (req_ready !== RR_G[c]) begin tests_failed++; $display("FAIL rr_ready c%0d: got %h want %h", c, req_ready, RR_G[c]); end
      tests_run++;
      if (wr_uart !== (RR_D[c] != 8'h00)) begin tests_failed++; $display("FAIL rr_wr c%0d: got %b", c, wr_uart); end
      tests_run++;
      if (w_data !== RR_D[c]) begin tests_failed++; $display("FAIL rr_wdata c%0d: got %h want %h", c, w_data, RR_D[c]); end
    end
    req_valid = '0;
    tests_run++;
    if (wlog.size() - start != 5) begin
      tests_failed++; $display("FAIL rr_log_len: got %0d want 5", wlog.size() - start);
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests_run++;
        if (wlog[start+k] !== RR_L[k]) begin tests_failed++; $display("FAIL rr_log %0d: got %h want %h", k, wlog[start+k], RR_L[k]); end
      end
    end
  endtask

  task automatic test_burst_limit();
    int start;
    int idx;
    start      = wlog.size();
    idx        = 0;
    req_enable = '1;
    tx_full    = 1'b0;
    req_data   = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge PCLK);
      if (idx < 5) begin
        req_valid = 4'b0100;
        req_data[2*BW +: BW] = BS_S[idx];
        req_last  = (idx == 4) ? 4'b0100 : 4'b0000;
      end else begin
        req_valid = '0;
        req_last  = '0;
      end
      #1;
      tests_run++;
      if (grant !== BS_G[c]) begin tests_failed++; $display("FAIL burst_grant c%0d: got %h want %h", c, grant, BS_G[c]); end
      tests_run++;
      if (w_data !== BS_D[c]) begin tests_failed++; $display("FAIL burst_wdata c%0d: got %h want %h", c, w_data, BS_D[c]); end
      tests_run++;
      if (req_ready !== ((BS_D[c] != 8'h00) ? 4'b0100 : 4'b0000)) begin
        tests_failed++; $display("FAIL burst_ready c%0d: got %h", c, req_ready);
      end
      if (req_ready[2]) idx++;
    end
    req_valid = '0;
    tests_run++;
    if (idx != 5) begin tests_failed++; $display("FAIL burst_consumed: got %0d want 5", idx); end
    tests_run++;
    if (wlog.size() - start != 5) begin
      tests_failed++; $display("FAIL burst_log_len: got %0d want 5", wlog.size() - start);
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests_run++;
        if (wlog[start+k] !== {4'h4, BS_S[k]}) begin tests_failed++; $display("FAIL burst_log %0d: got %h want %h", k, wlog[start+k], {4'h4, BS_S[k]}); end
      end
    end
  endtask

  task automatic test_tx_full();
    int start;
    int idx;
    start      = wlog.size();
    idx        = 0;
    req_enable = '1;
    req_data   = '0;
    for (int c = 0; c < 11; c++) begin
      @(negedge PCLK);
      tx_full = TF_F[c];
      if (idx < 4) begin
        req_valid = 4'b0010;
        req_data[1*BW +: BW] = TF_S[idx];
        req_last  = (idx == 3) ? 4'b0010 : 4'b0000;
      end else begin
        req_valid = '0;
        req_last  = '0;
      end
      #1;
      tests_run++;
      if (grant !== TF_G[c]) begin tests_failed++; $display("FAIL full_grant c%0d: got %h want %h", c, grant, TF_G[c]); end
      tests_run++;
      if (wr_uart !== (TF_D[c] != 8'h00)) begin tests_failed++; $display("FAIL full_wr c%0d: got %b", c, wr_uart); end
      tests_run++;
      if (w_data !== TF_D[c]) begin tests_failed++; $display("FAIL full_wdata c%0d: got %h want %h", c, w_data, TF_D[c]); end
      tests_run++;
      if (req_ready !== ((TF_D[c] != 8'h00) ? 4'b0010 : 4'b0000)) begin
        tests_failed++; $display("FAIL full_ready c%0d: got %h", c, req_ready);
      end
      if (req_ready[1]) idx++;
    end
    req_valid = '0;
    tx_full   = 1'b0;
    tests_run++;
    if (wlog.size() - start != 4) begin
      tests_failed++; $display("FAIL full_log_len: got %0d want 4", wlog.size() - start);
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (wlog[start+k] !== {4'h2, TF_S[k]}) begin tests_failed++; $display("FAIL full_log %0d: got %h want %h", k, wlog[start+k], {4'h2, TF_S[k]}); end
      end
    end
  endtask

  task automatic test_enable_drop();
    int start;
    start    = wlog.size();
    tx_full  = 1'b0;
    req_data = {8'h00, 8'hE2, 8'hB0, 8'hE0};
    req_last = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      @(negedge PCLK);
      req_valid  = ED_V[c];
      req_enable = ED_EN[c];
      #1;
      tests_run++;
      if (grant !== ED_G[c]) begin tests_failed++; $display("FAIL endrop_grant c%0d: got %h want %h", c, grant, ED_G[c]); end
      tests_run++;
      if (w_data !== ED_D[c]) begin tests_failed++; $display("FAIL endrop_wdata c%0d: got %h want %h", c, w_data, ED_D[c]); end
      tests_run++;
      if (wr_uart !== (ED_D[c] != 8'h00)) begin tests_failed++; $display("FAIL endrop_wr c%0d: got %b", c, wr_uart); end
    end
    req_valid  = '0;
    req_enable = '1;
    tests_run++;
    if (wlog.size() - start != 2) begin
      tests_failed++; $display("FAIL endrop_log_len: got %0d want 2", wlog.size() - start);
    end else begin
      tests_run++;
      if (wlog[start] !== 12'h2B0) begin tests_failed++; $display("FAIL endrop_log 0: got %h want 2b0", wlog[start]); end
      tests_run++;
      if (wlog[start+1] !== 12'h4E2) begin tests_failed++; $display("FAIL endrop_log 1: got %h want 4e2", wlog[start+1]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int start;
    start      = wlog.size();
    tx_full    = 1'b0;
    req_enable = '1;
    req_last   = 4'b0001;
    req_data   = {8'h71, 8'h00, 8'h00, 8'h0F};
    for (int c = 0; c < 8; c++) begin
      @(negedge PCLK);
      req_valid = RM_V[c];
      req_data[3*BW +: BW] = RM_3[c];
      PRESETN   = RM_R[c];
      #1;
      tests_run++;
      if (grant !== RM_G[c]) begin tests_failed++; $display("FAIL rstmid_grant c%0d: got %h want %h", c, grant, RM_G[c]); end
      tests_run++;
      if (busy !== (RM_G[c] != 4'h0)) begin tests_failed++; $display("FAIL rstmid_busy c%0d: got %b", c, busy); end
      tests_run++;
      if (w_data !== RM_D[c]) begin tests_failed++; $display("FAIL rstmid_wdata c%0d: got %h want %h", c, w_data, RM_D[c]); end
      tests_run++;
      if (req_ready !== ((RM_D[c] != 8'h00) ? RM_G[c] : 4'h0)) begin
        tests_failed++; $display("FAIL rstmid_ready c%0d: got %h", c, req_ready);
      end
    end
    req_valid = '0;
    tests_run++;
    if (wlog.size() - start != 3) begin
      tests_failed++; $display("FAIL rstmid_log_len: got %0d want 3", wlog.size() - start);
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (wlog[start+k] !== RM_L[k]) begin tests_failed++; $display("FAIL rstmid_log %0d: got %h want %h", k, wlog[start+k], RM_L[k]); end
      end
    end
  endtask

  task automatic test_scoreboard();
    repeat (2) @(negedge PCLK);
    tests_run++;
    if (full_viol != 0) begin tests_failed++; $display("FAIL write_while_full: got %0d want 0", full_viol); end
    tests_run++;
    if (wlog.size() != 19) begin tests_failed++; $display("FAIL total_writes: got %0d want 19", wlog.size()); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst_limit();
    test_tx_full();
    test_enable_drop();
    test_reset_mid_burst();
    test_scoreboard();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
